// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Brief    : Four-state fetch/decode/execute/writeback controller with start,
//            single-step and halt control for the 8-bit processor datapath.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter int PC_W        = 4,
    parameter int JUMP_TARGET = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_single_step,
    input  logic [7:0]      i_instr_in,
    output logic [PC_W-1:0] o_pc_out,
    output logic [7:0]      o_ir_out,
    output logic [1:0]      o_rs1,
    output logic [1:0]      o_rs2,
    output logic [1:0]      o_rd,
    output logic [2:0]      o_alu_op,
    output logic            o_reg_write,
    output logic            o_busy,
    output logic            o_halted,
    output logic [2:0]      o_state,
    output logic [7:0]      o_retired
);

    localparam logic [PC_W-1:0] c_JUMP_PC  = PC_W'(JUMP_TARGET);
    localparam logic [7:0]      c_HALT_IR  = 8'hFF;
    localparam logic [1:0]      c_OP_JUMP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_ir;
    logic [7:0]      r_retired;
    logic            w_retire;
    logic            w_is_jump;

    assign w_is_jump = (r_ir[7:6] == c_OP_JUMP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_FETCH) begin
                r_ir <= i_instr_in;
            end
            if (r_state == S_WRITEBACK) begin
                r_pc <= w_is_jump ? c_JUMP_PC : r_pc + PC_W'(1);
            end
            if (w_retire && (r_retired != 8'hFF)) begin
                r_retired <= r_retired + 8'd1;
            end
        end
    end

    // A HALT instruction counts as retired when it leaves DECODE.
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        case (r_state)
            S_IDLE:      if (i_start) w_next_state = S_FETCH;
            S_FETCH:     w_next_state = S_DECODE;
            S_DECODE: begin
                if (r_ir == c_HALT_IR) begin
                    w_next_state = S_HALT;
                    w_retire     = 1'b1;
                end else begin
                    w_next_state = S_EXECUTE;
                end
            end
            S_EXECUTE:   w_next_state = S_WRITEBACK;
            S_WRITEBACK: begin
                w_retire     = 1'b1;
                w_next_state = i_single_step ? S_IDLE : S_FETCH;
            end
            S_HALT:      w_next_state = S_HALT;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_alu_op    = 3'b000;
        o_reg_write = 1'b0;
        if ((r_state == S_EXECUTE) || (r_state == S_WRITEBACK)) begin
            case (r_ir[7:6])
                2'b00:   o_alu_op = 3'b001;
                2'b01:   o_alu_op = 3'b010;
                2'b10:   o_alu_op = 3'b011;
                default: o_alu_op = 3'b000;
            endcase
        end
        if ((r_state == S_WRITEBACK) && !w_is_jump) begin
            o_reg_write = 1'b1;
        end
    end

    assign o_pc_out  = r_pc;
    assign o_ir_out  = r_ir;
    assign o_rs1     = r_ir[5:4];
    assign o_rs2     = r_ir[3:2];
    assign o_rd      = r_ir[1:0];
    assign o_busy    = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                       (r_state == S_EXECUTE) || (r_state == S_WRITEBACK);
    assign o_halted  = (r_state == S_HALT);
    assign o_state   = r_state;
    assign o_retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Brief    : Directed scoreboard bench for cpu_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       single_step;
    logic [7:0] instr;
    logic [3:0] pc_out;
    logic [7:0] ir_out;
    logic [1:0] rs1, rs2, rd;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       busy;
    logic       halted;
    logic [2:0] state;
    logic [7:0] retired;

    logic [7:0] mem [16];

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rw_total = 0;
    int   rw_base;

    cpu_sequencer #(.PC_W(4), .JUMP_TARGET(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .i_single_step(single_step),
        .i_instr_in   (instr),
        .o_pc_out     (pc_out),
        .o_ir_out     (ir_out),
        .o_rs1        (rs1),
        .o_rs2        (rs2),
        .o_rd         (rd),
        .o_alu_op     (alu_op),
        .o_reg_write  (reg_write),
        .o_busy       (busy),
        .o_halted     (halted),
        .o_state      (state),
        .o_retired    (retired)
    );

    assign instr = mem[pc_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file write strobes as seen by the datapath at each edge.
    always @(posedge clk) if (reg_write) rw_total++;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%0d", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        single_step = 1'b0;
        fill_mem(8'h00);
        mem[0] = 8'h1B;
        #1;
        do_reset();

        // ---- reset state ----
        push("rst_state", 0); push("rst_pc", 0); push("rst_ir", 0);
        push("rst_retired", 0); push("rst_alu", 0); push("rst_rw", 0);
        push("rst_busy", 0); push("rst_halted", 0);
        chk(32'(state)); chk(32'(pc_out)); chk(32'(ir_out)); chk(32'(retired));
        chk(32'(alu_op)); chk(32'(reg_write)); chk(32'(busy)); chk(32'(halted));

        // ---- single ADD 8'h1B ----
        push("t1_c1_state", 1);
        push("t1_c2_state", 2); push("t1_c2_ir", 8'h1B);
        push("t1_c3_state", 3); push("t1_c3_alu", 1);
        push("t1_c4_state", 4); push("t1_c4_alu", 1); push("t1_c4_rs1", 1);
        push("t1_c4_rs2", 2); push("t1_c4_rd", 3); push("t1_c4_rw", 1);
        push("t1_c4_pc", 0);
        push("t1_c5_state", 1); push("t1_c5_pc", 1); push("t1_c5_retired", 1);
        pulse_start();
        chk(32'(state));
        tick(1); chk(32'(state)); chk(32'(ir_out));
        tick(1); chk(32'(state)); chk(32'(alu_op));
        tick(1); chk(32'(state)); chk(32'(alu_op)); chk(32'(rs1));
        chk(32'(rs2)); chk(32'(rd)); chk(32'(reg_write)); chk(32'(pc_out));
        tick(1); chk(32'(state)); chk(32'(pc_out)); chk(32'(retired));

        // ---- AND, OR, JUMP ----
        do_reset();
        mem[0] = 8'h46; mem[1] = 8'h9E; mem[2] = 8'hC0;
        push("t2_and_alu", 3'b010); push("t2_and_rw", 1);
        push("t2_or_alu", 3'b011);  push("t2_or_rw", 1);
        push("t2_jmp_alu", 3'b000); push("t2_jmp_rw", 0);
        push("t2_jmp_pc", 0); push("t2_retired", 3);
        pulse_start();
        tick(3); chk(32'(alu_op)); chk(32'(reg_write));
        tick(4); chk(32'(alu_op)); chk(32'(reg_write));
        tick(4); chk(32'(alu_op)); chk(32'(reg_write));
        tick(1); chk(32'(pc_out)); chk(32'(retired));

        // ---- single step ----
        do_reset();
        fill_mem(8'h00);
        single_step = 1'b1;
        push("t3_idle_state", 0); push("t3_idle_busy", 0);
        push("t3_hold_state", 0); push("t3_hold_pc", 1); push("t3_hold_retired", 1);
        push("t3_restart_state", 1); push("t3_restart_pc", 1);
        pulse_start();
        tick(4); chk(32'(state)); chk(32'(busy));
        tick(10); chk(32'(state)); chk(32'(pc_out)); chk(32'(retired));
        pulse_start();
        chk(32'(state)); chk(32'(pc_out));
        single_step = 1'b0;

        // ---- HALT ----
        do_reset();
        mem[2] = 8'hFF;
        push("t4_state", 5); push("t4_halted", 1); push("t4_busy", 0);
        push("t4_pc", 2); push("t4_retired", 3);
        push("t4_post_state", 5); push("t4_post_retired", 3); push("t4_halt_writes", 0);
        pulse_start();
        tick(8);
        rw_base = rw_total;
        tick(2);
        chk(32'(state)); chk(32'(halted)); chk(32'(busy));
        chk(32'(pc_out)); chk(32'(retired));
        start = 1'b1;
        tick(3);
        start = 1'b0;
        chk(32'(state)); chk(32'(retired)); chk(32'(rw_total - rw_base));

        // ---- PC wrap and retired saturation ----
        do_reset();
        fill_mem(8'h00);
        push("t5_pc15", 15); push("t5_pc_wrap", 0);
        push("t5_retired254", 254); push("t5_retired255", 255);
        push("t5_retired_sat", 255);
        pulse_start();
        for (int c = 1; c <= 1030; c++) begin
            if (c > 1) tick(1);
            if (c == 64) chk(32'(pc_out));
            if (c == 65) chk(32'(pc_out));
            if (c == 1017) chk(32'(retired));
            if (c == 1021) chk(32'(retired));
            if (c == 1030) chk(32'(retired));
        end

        // ---- async reset mid-EXECUTE ----
        do_reset();
        mem[0] = 8'h5B;
        push("t6_exec_state", 3);
        push("t6_state", 0); push("t6_pc", 0); push("t6_ir", 0); push("t6_retired", 0);
        push("t6_rw", 0); push("t6_alu", 0); push("t6_busy", 0);
        push("t6_no_write", 0);
        push("t6_restart_state", 1); push("t6_restart_pc", 0);
        pulse_start();
        tick(2);
        chk(32'(state));
        rw_base = rw_total;
        #2;
        rst = 1'b1;
        #1;
        chk(32'(state)); chk(32'(pc_out)); chk(32'(ir_out)); chk(32'(retired));
        chk(32'(reg_write)); chk(32'(alu_op)); chk(32'(busy));
        tick(2);
        rst = 1'b0;
        chk(32'(rw_total - rw_base));
        tick(1);
        pulse_start();
        chk(32'(state)); chk(32'(pc_out));

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle fetch/decode/execute/writeback controller for the 8-bit processor datapath: 4-bit PC, 16x8 instruction memory, 4x8 register file, 3-op ALU. It owns the PC and instruction register. It drives instruction-memory address, register-file read/write selects and write enable, and the ALU operation. Each instruction is spread over four clock states, and the block adds start, single-step and halt control. It sits between the top-level wrapper and the existing datapath blocks and replaces the single-cycle PC-update path.

## Interface
- PC_W, 4, PC and instruction-address width; PC wraps modulo 2^PC_W
- JUMP_TARGET, 0, PC value loaded by a jump instruction
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  leaves IDLE when sampled high in IDLE
- single_step  input  1  sampled at end of WRITEBACK; 1 = return to IDLE after this instruction
- instr_in  input  8  instruction-memory data for address pc_out (combinational memory)
- pc_out  output  PC_W  instruction-memory address
- ir_out  output  8  instruction register
- rs1, rs2, rd  output  2 each  ir_out[5:4], ir_out[3:2], ir_out[1:0]
- alu_op  output  3  ALU operation
- reg_write  output  1  register-file write enable
- busy  output  1  high in FETCH, DECODE, EXECUTE, WRITEBACK
- halted  output  1  high in HALT
- state  output  3  IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5
- retired  output  8  count of completed instructions, saturating at 255

## Operation
- Reset (async, any state, mid-instruction included):
  - state=IDLE, pc_out=0, ir_out=0, retired=0.
  - alu_op=000, reg_write=0, busy=0, halted=0.
  - An in-flight write is abandoned; reg_write must not glitch high.
- Opcode map, from ir_out[7:6]:
  - 00: ADD, alu_op 001
  - 01: AND, alu_op 010
  - 10: OR, alu_op 011
  - 11: JUMP, alu_op 000, no write
  - 8'hFF is HALT (a JUMP with operand 6'h3F).
- State transitions:
  - IDLE -> FETCH when start=1. Otherwise stay.
  - FETCH -> DECODE; ir_out <= instr_in at the FETCH->DECODE edge.
  - DECODE -> EXECUTE, except ir_out==8'hFF -> HALT.
  - EXECUTE -> WRITEBACK.
  - WRITEBACK -> IDLE if single_step=1, else FETCH.
  - HALT: stays until rst; start is ignored.
- alu_op and rd/rs1/rs2 outputs:
  - alu_op is driven from ir_out in EXECUTE and WRITEBACK only; it is 000 in every other state.
  - rs1, rs2 and rd are continuous slices of ir_out.
- reg_write:
  - High only in WRITEBACK, and only for opcodes 00, 01 and 10.
  - The register file captures ALU output at the WRITEBACK->next edge.
- PC update, at the end of WRITEBACK:
  - JUMP: pc_out <= JUMP_TARGET.
  - Otherwise pc_out <= pc_out+1, truncated to PC_W (15 -> 0).
- HALT entry: PC is unchanged. retired increments once at DECODE->HALT.
- retired increments at the end of each WRITEBACK and saturates at 255.
- start asserted outside IDLE has no effect. single_step is sampled only in WRITEBACK.

## Timing
- Latency: start sampled at edge 0 gives the state sequence below.

  | Cycle | State |
  |---|---|
  | 1 | FETCH |
  | 2 | DECODE |
  | 3 | EXECUTE |
  | 4 | WRITEBACK |
  | 5 | next FETCH |

- Throughput: one instruction per 4 cycles.
- ir_out is valid from cycle 2. alu_op is valid in cycles 3–4. reg_write is high in cycle 4 only.
- pc_out holds constant throughout FETCH..WRITEBACK and changes only at the WRITEBACK exit edge.
- All outputs are registered or decoded from registered state/ir_out only; there is no combinational path from start, single_step or instr_in to any output.
- Single-step: after WRITEBACK the block is in IDLE. The next start re-enters FETCH one cycle later with the updated PC.

## Test plan
- Reset, then start with mem[0]=8'h1B, single_step=0:
  - state goes 1,2,3,4.
  - In cycle 4: alu_op=001, rs1=1, rs2=2, rd=3, reg_write=1.
  - pc_out becomes 1 in cycle 5; retired=1.
- Jump and sequencing, with mem[0..2]={8'h46, 8'h9E, 8'hC0}:
  - alu_op goes 010 then 011.
  - reg_write is low for 8'hC0.
  - pc_out returns to 0 after the third WRITEBACK; retired=3.
- Single-step with single_step=1:
  - After one instruction, state=0 and busy=0, held for 10 idle cycles.
  - A start pulse gives FETCH on the next cycle with pc_out=1.
- HALT, with mem[2]=8'hFF:
  - After DECODE of 8'hFF: state=5, halted=1, pc_out=2, retired=3, reg_write never asserted.
  - start is ignored afterwards.
- PC wrap and counter saturation, with all 16 entries 8'h00 (ADD r0,r0->r0), free-running:
  - pc_out goes 15 -> 0.
  - retired stops at 255 after 255 instructions.
- Async reset asserted mid-EXECUTE, between clock edges:
  - All outputs return to reset values immediately.
  - No register-file write occurs.
  - After release, start restarts from pc_out=0.
